// File: rtl/bats_feed_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : bats_feed_arbiter
// Brief   : Round-robin whole-packet arbiter sharing one BATS PITCH parser
//           between several UDP payload feeds, with idle-gap insertion and
//           parser resync on malformed input.
// Rev     : 1.0  initial release
// ============================================================================
module bats_feed_arbiter #(
    parameter int NUM_FEEDS = 2,
    parameter int MAX_BEATS = 192,
    parameter int IDLE_GAP  = 2
) (
    input  logic                    Clk40,
    input  logic                    reset_n,
    input  logic                    sw_reset,
    input  logic [NUM_FEEDS*64-1:0] feed_bytes,
    input  logic [NUM_FEEDS*8-1:0]  feed_byte_enables,
    input  logic [NUM_FEEDS-1:0]    feed_valid,
    input  logic [NUM_FEEDS-1:0]    feed_last,
    output logic [NUM_FEEDS-1:0]    feed_ready,
    output logic [63:0]             parser_bytes,
    output logic [7:0]              parser_byte_enables,
    output logic                    parser_data_valid,
    output logic                    parser_reset,
    input  logic                    parser_ready_for_udp_input,
    output logic [2:0]              grant_id,
    output logic [31:0]             packets_forwarded,
    output logic [15:0]             packets_truncated,
    output logic                    overrun
);

    localparam int c_CNT_W = $clog2(MAX_BEATS + 1);
    localparam int c_GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_BURST = 2'd1;
    localparam logic [1:0] c_S_FLUSH = 2'd2;
    localparam logic [1:0] c_S_GAP   = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [2:0]         r_grant;
    logic [2:0]         r_ptr;
    logic [c_CNT_W-1:0] r_beat_cnt;
    logic [c_GAP_W-1:0] r_gap_cnt;

    logic [63:0]        w_sel_bytes;
    logic [7:0]         w_sel_be;
    logic               w_sel_valid;
    logic               w_sel_last;
    logic               w_rr_found;
    logic [2:0]         w_rr_idx;

    logic               w_own;
    logic               w_accept;
    logic               w_fwd;
    logic               w_good;
    logic               w_trunc;
    logic               w_grant_en;
    logic               w_gap_done;
    logic               w_beat_hit_max;

    // Mux of the currently granted feed
    always_comb begin
        w_sel_bytes = '0;
        w_sel_be    = '0;
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        for (int i = 0; i < NUM_FEEDS; i++) begin
            if (r_grant == 3'(i)) begin
                w_sel_bytes = feed_bytes[i*64 +: 64];
                w_sel_be    = feed_byte_enables[i*8 +: 8];
                w_sel_valid = feed_valid[i];
                w_sel_last  = feed_last[i];
            end
        end
    end

    // First valid feed searching upward from pointer+1, wrapping
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        for (int k = 1; k <= NUM_FEEDS; k++) begin
            for (int i = 0; i < NUM_FEEDS; i++) begin
                if (!w_rr_found && feed_valid[i] &&
                    ((int'(r_ptr) + k) % NUM_FEEDS == i)) begin
                    w_rr_found = 1'b1;
                    w_rr_idx   = 3'(i);
                end
            end
        end
    end

    assign w_beat_hit_max = (r_beat_cnt == c_CNT_W'(MAX_BEATS - 1));

    for (genvar gi = 0; gi < NUM_FEEDS; gi++) begin : g_ready
        assign feed_ready[gi] = w_own && (r_grant == 3'(gi));
    end

    assign grant_id = r_grant;

    // FSM: state register
    always_ff @(posedge Clk40 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM: next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_grant_en) w_next_state = c_S_BURST;
            end
            c_S_BURST: begin
                // A soft reset still drains the rest of the packet unless it just ended
                if (sw_reset)     w_next_state = (w_accept && w_sel_last) ? c_S_GAP : c_S_FLUSH;
                else if (w_good)  w_next_state = c_S_GAP;
                else if (w_trunc) w_next_state = c_S_FLUSH;
            end
            c_S_FLUSH: begin
                if (w_accept && w_sel_last) w_next_state = c_S_GAP;
            end
            default: begin
                if (sw_reset || w_gap_done) w_next_state = c_S_IDLE;
            end
        endcase
    end

    // FSM: output strobes
    always_comb begin
        w_own      = (r_state == c_S_BURST) || (r_state == c_S_FLUSH);
        w_accept   = w_own && w_sel_valid;
        w_fwd      = 1'b0;
        w_good     = 1'b0;
        w_trunc    = 1'b0;
        w_grant_en = 1'b0;
        w_gap_done = (r_gap_cnt == c_GAP_W'(IDLE_GAP - 1));
        case (r_state)
            c_S_IDLE: begin
                w_grant_en = !sw_reset && parser_ready_for_udp_input && w_rr_found;
            end
            c_S_BURST: begin
                if (!sw_reset) begin
                    w_fwd = w_sel_valid;
                    if (!w_sel_valid)        w_trunc = 1'b1;
                    else if (w_sel_last)     w_good  = 1'b1;
                    else if (w_beat_hit_max) w_trunc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath, grant bookkeeping and statistics
    always_ff @(posedge Clk40 or negedge reset_n) begin
        if (!reset_n) begin
            parser_bytes        <= '0;
            parser_byte_enables <= '0;
            parser_data_valid   <= 1'b0;
            parser_reset        <= 1'b0;
            r_grant             <= '0;
            r_ptr               <= 3'(NUM_FEEDS - 1);
            r_beat_cnt          <= '0;
            r_gap_cnt           <= '0;
            packets_forwarded   <= '0;
            packets_truncated   <= '0;
            overrun             <= 1'b0;
        end else begin
            parser_data_valid <= w_fwd;
            if (w_fwd) begin
                parser_bytes        <= w_sel_bytes;
                parser_byte_enables <= w_sel_be;
            end
            parser_reset <= sw_reset || w_trunc;

            if (w_grant_en) begin
                r_grant    <= w_rr_idx;
                r_ptr      <= w_rr_idx;
                r_beat_cnt <= '0;
            end else if (w_fwd) begin
                r_beat_cnt <= r_beat_cnt + c_CNT_W'(1);
            end

            if (r_state == c_S_GAP) r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
            else                    r_gap_cnt <= '0;

            if (sw_reset) begin
                packets_forwarded <= '0;
                packets_truncated <= '0;
                overrun           <= 1'b0;
            end else begin
                if (w_good) packets_forwarded <= packets_forwarded + 32'd1;
                if (w_trunc && (packets_truncated != 16'hFFFF))
                    packets_truncated <= packets_truncated + 16'd1;
                // Parser has one packet of slack, so a mid-burst drop is only flagged
                if ((r_state == c_S_BURST) && !parser_ready_for_udp_input)
                    overrun <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
